// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} md_state_t;

  typedef enum logic [2:0] {
    OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
  } md_op_t;

  function automatic logic is_div(md_op_t op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic is_rem(md_op_t op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic is_signed_a(md_op_t op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_signed_b(md_op_t op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath with sign fix-up.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            prep_i,
  input  logic            calc_i,
  input  logic            fix_i,
  input  logic            early_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            div_zero_o,
  output logic            overflow_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  md_op_t              op_q;
  logic [XLEN-1:0]     a_q, b_q, res_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q;

  logic                sign_a, sign_b, neg_d;
  logic [XLEN-1:0]     abs_a, abs_b, early_res, fix_res;
  logic [XLEN:0]       add_sum, rem_ext, diff;
  logic [2*XLEN-1:0]   acc_step, prod;

  always_comb begin
    sign_a     = is_signed_a(op_q) & a_q[XLEN-1];
    sign_b     = is_signed_b(op_q) & b_q[XLEN-1];
    abs_a      = sign_a ? -a_q : a_q;
    abs_b      = sign_b ? -b_q : b_q;
    div_zero_o = is_div(op_q) && (b_q == '0);
    overflow_o = is_div(op_q) && is_signed_a(op_q) && (a_q == MinInt) && (b_q == '1);

    // A zero divisor must leave the all-ones quotient un-negated.
    if (!is_div(op_q))      neg_d = sign_a ^ sign_b;
    else if (is_rem(op_q))  neg_d = sign_a;
    else                    neg_d = (sign_a ^ sign_b) & ~div_zero_o;

    if (div_zero_o) early_res = is_rem(op_q) ? a_q : '1;
    else            early_res = is_rem(op_q) ? '0 : MinInt;

    // Multiply: hi half accumulates, lo half holds the multiplier being shifted out.
    add_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q})
                       : {1'b0, acc_q[2*XLEN-1:XLEN]};
    // Divide: hi half is the partial remainder, lo half collects quotient bits.
    rem_ext = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_ext - {1'b0, b_q};
    if (!is_div(op_q))  acc_step = {add_sum, acc_q[XLEN-1:1]};
    else if (diff[XLEN]) acc_step = {rem_ext[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod    = neg_q ? -acc_q : acc_q;
    fix_res = '0;
    case (op_q)
      OpMul:                     fix_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                   fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN]
                                                 : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= OpMul;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else if (load_i) begin
      op_q <= md_op_t'(funct3_i);
      a_q  <= op_a_i;
      b_q  <= op_b_i;
    end else if (prep_i) begin
      a_q   <= abs_a;
      b_q   <= abs_b;
      acc_q <= is_div(op_q) ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
      neg_q <= neg_d;
      if (early_i) res_q <= early_res;
    end else if (calc_i) begin
      acc_q <= acc_step;
    end else if (fix_i) begin
      res_q <= fix_res;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, bit counter and pipeline stall handshake.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            dbg,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q;
  logic            run, load, prep_en, calc_en, fix_en, early, div_zero, overflow;

  assign early = EARLY_OUT && (div_zero || overflow);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) rd_q <= rd_in;
    end
  end

  // Flush wins over dbg; dbg freezes everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!dbg) begin
      unique case (state_q)
        IDLE: if (start) state_d = PREP;
        PREP: begin
          cnt_d   = CntW'(XLEN);
          state_d = early ? DONE : CALC;
        end
        CALC: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_d = FIX;
        end
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run     = !dbg && !flush;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    stall   = ((state_q == IDLE) && start) || (state_q == PREP) || (state_q == CALC) ||
              (state_q == FIX);
    load    = (state_q == IDLE) && start && run;
    prep_en = (state_q == PREP) && run;
    calc_en = (state_q == CALC) && run;
    fix_en  = (state_q == FIX) && run;
  end

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk_i      (clk),
    .rst_i      (Rst),
    .load_i     (load),
    .prep_i     (prep_en),
    .calc_i     (calc_en),
    .fix_i      (fix_en),
    .early_i    (early),
    .funct3_i   (funct3),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .div_zero_o (div_zero),
    .overflow_o (overflow),
    .result_o   (result)
  );

  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: early-out and no-early-out instances driven in lockstep.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        Rst, dbg, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        stall1, busy1, done1, stall0, busy0, done0;
  logic [31:0] result1, result0;
  logic [4:0]  rd_out1, rd_out0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .EARLY_OUT(1'b1)) dut_e (
    .clk(clk), .Rst(Rst), .dbg(dbg), .flush(flush), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall1), .busy(busy1), .done(done1),
    .result(result1), .rd_out(rd_out1)
  );

  muldiv_sequencer #(.XLEN(32), .EARLY_OUT(1'b0)) dut_n (
    .clk(clk), .Rst(Rst), .dbg(dbg), .flush(flush), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall0), .busy(busy0), .done(done0),
    .result(result0), .rd_out(rd_out0)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t sb1[$];
  exp_t sb0[$];
  vec_t vecs[19];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Called at #1 after a posedge with both DUTs idle; start is sampled at the next edge (cycle T).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input int lat1,
                        input int dbg_at);
    int   st = 0;
    int   shift = (dbg_at > 0) ? 10 : 0;
    bit   got1 = 0, got0 = 0;
    exp_t e;
    e.res = expv; e.rd = rd; e.lat = lat1 + shift; sb1.push_back(e);
    e.lat = 35 + shift; sb0.push_back(e);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1 if (stall1) st++;
    for (int k = 1; k <= 90 && !(got1 && got0); k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (stall1) st++;
      if (done1 && !got1) begin
        got1 = 1; e = sb1.pop_front();
        chk("result_early", result1, e.res);
        chk("rd_out_early", rd_out1, e.rd);
        chk("latency_early", 32'(k), 32'(e.lat));
      end
      if (done0 && !got0) begin
        got0 = 1; e = sb0.pop_front();
        chk("result_noearly", result0, e.res);
        chk("latency_noearly", 32'(k), 32'(e.lat));
      end
      if (dbg_at > 0 && k == dbg_at) dbg = 1'b1;
      if (dbg_at > 0 && k == dbg_at + 10) dbg = 1'b0;
    end
    if (!got1) begin
      n_checks++; n_fail++; void'(sb1.pop_front());
      $display("FAIL timeout_early: got no done, expected done within budget");
    end
    if (!got0) begin
      n_checks++; n_fail++; void'(sb0.pop_front());
      $display("FAIL timeout_noearly: got no done, expected done within budget");
    end
    chk("stall_cycles", 32'(st), 32'(lat1 + shift));
    @(posedge clk); #1;
    chk("done_one_cycle", {30'd0, done1, done0}, 32'd0);
    chk("idle_after_done", {30'd0, busy1, busy0}, 32'd0);
  endtask

  initial begin
    int dones;
    Rst = 1'b0; dbg = 1'b0; flush = 1'b0; start = 1'b0;
    funct3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
    #2 Rst = 1'b1;
    #1;
    chk("reset_ctrl", {29'd0, stall1, busy1, done1}, 32'd0);
    chk("reset_result", result1, 32'd0);
    chk("reset_rd", {27'd0, rd_out1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {28'd0, stall1, busy1, stall0, busy0}, 32'd0);

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 35};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 35};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 35};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 35};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 35};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 35};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        35};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         35};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         5'd14, 32'd5,         2};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         2};
    vecs[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd17, 32'hFFFF_FFFF, 2};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFF9, 2};
    vecs[14] = '{3'd0, 32'h1234_5678,  32'd0,         5'd19, 32'd0,         35};
    vecs[15] = '{3'd1, 32'hFFFF_FFFE,  32'd3,         5'd20, 32'hFFFF_FFFF, 35};
    vecs[16] = '{3'd5, 32'hFFFF_FFFF,  32'h10,        5'd21, 32'h0FFF_FFFF, 35};
    vecs[17] = '{3'd7, 32'hFFFF_FFFF,  32'h10,        5'd22, 32'hF,         35};
    vecs[18] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd23, 32'd0,         35};

    for (int i = 0; i < 19; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 0);

    // dbg freeze for 10 cycles in CALC pushes done out by 10.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd24, 32'hFFFF_FFEB, 35, 5);

    // Flush mid-CALC: back to IDLE next cycle, no done afterwards.
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 10) flush = 1'b1;
      if (k == 11) flush = 1'b0;
    end
    chk("flush_idle", {28'd0, busy1, stall1, busy0, stall0}, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done1 || done0) dones++;
    end
    chk("flush_no_done", 32'(dones), 32'd0);

    // Flush beats start in IDLE: nothing latched.
    rd_in = 5'd30; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("flush_beats_start_rd", {27'd0, rd_out1}, 32'd21);

    // Asynchronous reset mid-DIV.
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd22; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {29'd0, stall1, busy1, done1}, 32'd0);
    chk("async_rst_result", result1, 32'd0);
    chk("async_rst_rd", {27'd0, rd_out1}, 32'd0);
    chk("async_rst_noearly", {30'd0, busy0, stall0}, 32'd0);
    @(posedge clk); #1 Rst = 1'b0;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd23, 32'hFFFF_FFFD, 35, 0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op(f, a, b, 5'(i + 1), ref_md(f, a, b), ref_lat(f, a, b), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
